flag_reg_file: RTL and testbench
================================

// Module: flag_reg_file
// PURPOSE
//  Parametrised successor flag unit: owns the flag register (N,Z,L,V,I by default).
//  - Takes per-flag updates from the ALU and bus writes from the IBus high byte.
//  - Decodes flag actions and drives flags onto the IBus and the front panel.
//  - Sits between the ALU, the microcode read/write decoders and the front panel.
// PARAMETERS
//  BUS_W      8        width of flag bus slice (ibus[15:8]) and fpd
//  NFLAGS     6        flag bits held; bit map 0=N 1=Z 2=L 3=V 4=rsvd 5=I
//  FLAG_LSB   2        bus bit of flag[0]; NFLAGS+FLAG_LSB <= BUS_W
//  RSVD_MASK  6'b010000  bits held at 0; ignored on write, read as 0
//  WA_FLAGS0  5'b01101 first waddr selecting flag write
//  WA_FLAGS1  5'b01110 second waddr selecting flag write
//  RA_FLAGS   5'b01101 raddr selecting flag read
// PORTS
//  clk4       in   1        CPU clock; all state on rising edge
//  nreset     in   1        synchronous, active-low reset
//  waddr      in   5        write unit address
//  raddr      in   5        read unit address
//  action     in   4        action field
//  ibus       inout BUS_W   IBus high slice
//  alu_f      in   NFLAGS   new flag values from ALU
//  alu_we     in   NFLAGS   per-flag ALU update enables
//  nint_enter in   1        interrupt entry strobe, active low
//  nrti       in   1        return-from-interrupt strobe, active low
//  nfpflags   in   1        front-panel read request, active low, async
//  fpd        out  BUS_W    front-panel data, tri-state
//  flags      out  NFLAGS   current flag register
//  nflagwe    out  1        low when waddr is WA_FLAGS0 or WA_FLAGS1
//  nwrite_ir  out  1        low when waddr==5'b01111
//  nread_agl  out  1        low when raddr==5'b01111
// BEHAVIOUR
//  Reset (nreset low at clk4 edge): flags=0, snapshot=0, shadow=0, sync flops=1.
//  - ibus and fpd are Z during reset.
//  Decode: nflagwe, nwrite_ir, nread_agl combinational, no clock latency.
//  Read: raddr==RA_FLAGS -> ibus[FLAG_LSB+:NFLAGS]=flags; other bits 0; else Z.
//  Update priority per edge: reset > int_enter > rti > bus write > action > ALU.
//  - Bus write (nflagwe low): flags <= ibus[FLAG_LSB+:NFLAGS] & ~RSVD_MASK.
//  - Action 1=CPL (L<=~L), 2=CLL (L<=0), 3=STI (I<=1), 4=CLI (I<=0).
//  - Other action codes are no-ops.
//  - ALU: bits with alu_we=1 take alu_f unless an action targets the same bit.
//  - Action and ALU on different bits apply in the same cycle.
//  - Updates are visible on flags one edge later; 1-cycle latency.
//  Front panel:
//  - nfpflags passes through a 2-flop synchroniser.
//  - snapshot<=flags every edge while synced nfpflags=1; frozen while 0.
//  - fpd = raw nfpflags low ? snapshot placed as on ibus : Z.
//  - Request held across reset: after reset, snapshot=0 until release.
// CONFIGURATION
//  FLAG_SHADOW_EN defined: one-deep shadow register.
//  - nint_enter low: shadow<=flags; flags.I<=0; other bits keep value.
//  - nrti low: flags<=shadow & ~RSVD_MASK.
//  - Both low in one cycle: int_enter wins. A second entry before rti overwrites shadow.
//  FLAG_SHADOW_EN undefined: no shadow storage; nint_enter/nrti ignored.
// TESTING
//  Decode sweep: raddr/waddr 0..31 -> nflagwe low only at 01101/01110;
//  - nwrite_ir low only at 01111; nread_agl low only at 01111.
//  Bus write: ibus[15:8]=8'hFC, waddr=01101, one clk4 -> flags=6'b101111.
//  - raddr=01101 -> ibus[15:8]=8'hBC.
//  Priority: bus write 8'h00 + action=1 + alu_we=all -> flags=0.
//  - Next cycle: action=1 with alu_we[2]=1, alu_f[2]=0 -> L=1.
//  Front panel: flags=6'h21, nfpflags low, then ALU sets Z -> fpd stays 8'h84 while low.
//  - Release -> fpd=Z; next request -> 8'h8C.
//  Shadow (FLAG_SHADOW_EN): flags=6'h2C, nint_enter pulse -> flags=6'h0C.
//  - nrti pulse -> 6'h2C. Without the macro: flags unchanged.
//  Reset mid-request: nreset low while nfpflags low -> flags=0, fpd=8'h00.

Source files
------------

// File: rtl/flag_reg_file_if.sv
// Flag-unit bus bundle: microcode addresses, ALU flag updates, IBus high slice and front panel.
// Tri-state nets are carried as value plus output-enable; ibus resolves the shared bus wire.
interface flag_reg_file_if #(
  parameter int unsigned BUS_W  = 8,
  parameter int unsigned NFLAGS = 6
);
  logic [4:0]        waddr;
  logic [4:0]        raddr;
  logic [3:0]        action;
  logic [BUS_W-1:0]  ibus_ext;
  logic [BUS_W-1:0]  ibus;
  logic [BUS_W-1:0]  ibus_drv;
  logic              ibus_oe;
  logic [NFLAGS-1:0] alu_f;
  logic [NFLAGS-1:0] alu_we;
  logic              nint_enter;
  logic              nrti;
  logic              nfpflags;
  logic [BUS_W-1:0]  fpd;
  logic              fpd_oe;
  logic [NFLAGS-1:0] flags;
  logic              nflagwe;
  logic              nwrite_ir;
  logic              nread_agl;

  // The flag unit wins the IBus whenever it drives; otherwise the bus carries the external value.
  assign ibus = ibus_oe ? ibus_drv : ibus_ext;

  modport master (
    output waddr, raddr, action, ibus_ext, alu_f, alu_we, nint_enter, nrti, nfpflags,
    input  ibus, ibus_drv, ibus_oe, fpd, fpd_oe, flags, nflagwe, nwrite_ir, nread_agl
  );

  modport slave (
    input  waddr, raddr, action, ibus, alu_f, alu_we, nint_enter, nrti, nfpflags,
    output ibus_drv, ibus_oe, fpd, fpd_oe, flags, nflagwe, nwrite_ir, nread_agl
  );
endinterface

// File: rtl/flag_reg_file.sv
// Flag register unit (N,Z,L,V,rsvd,I): ALU/bus/action updates, IBus read, front-panel snapshot.
// Optional one-deep interrupt shadow register enabled by defining FLAG_SHADOW_EN.
module flag_reg_file #(
  parameter int unsigned       BUS_W     = 8,
  parameter int unsigned       NFLAGS    = 6,
  parameter int unsigned       FLAG_LSB  = 2,
  parameter logic [NFLAGS-1:0] RSVD_MASK = 6'b010000,
  parameter logic [4:0]        WA_FLAGS0 = 5'b01101,
  parameter logic [4:0]        WA_FLAGS1 = 5'b01110,
  parameter logic [4:0]        RA_FLAGS  = 5'b01101
) (
  input logic            clk4,
  input logic            nreset,
  flag_reg_file_if.slave bus
);

  localparam int unsigned BIT_L = 2;
  localparam int unsigned BIT_I = 5;

  typedef enum logic [3:0] {
    ACT_NOP = 4'd0,
    ACT_CPL = 4'd1,
    ACT_CLL = 4'd2,
    ACT_STI = 4'd3,
    ACT_CLI = 4'd4
  } action_e;

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [NFLAGS-1:0] snap_q;
  logic              sync1_q, sync2_q;
  logic [NFLAGS-1:0] act_mask, act_val, alu_res;
  logic [BUS_W-1:0]  flags_field, snap_field;
  logic              flag_wr;

  assign flag_wr       = (bus.waddr == WA_FLAGS0) || (bus.waddr == WA_FLAGS1);
  assign bus.nflagwe   = ~flag_wr;
  assign bus.nwrite_ir = ~(bus.waddr == 5'b01111);
  assign bus.nread_agl = ~(bus.raddr == 5'b01111);
  assign bus.flags     = flags_q;

  always_comb begin
    flags_field = '0;
    snap_field  = '0;
    flags_field[FLAG_LSB +: NFLAGS] = flags_q;
    snap_field[FLAG_LSB +: NFLAGS]  = snap_q;
  end

  // Both tri-state outputs float while reset is asserted.
  assign bus.ibus_oe  = nreset && (bus.raddr == RA_FLAGS);
  assign bus.ibus_drv = bus.ibus_oe ? flags_field : '0;
  assign bus.fpd_oe   = nreset && !bus.nfpflags;
  assign bus.fpd      = bus.fpd_oe ? snap_field : '0;

  always_comb begin
    act_mask = '0;
    act_val  = '0;
    case (bus.action)
      ACT_CPL: begin act_mask[BIT_L] = 1'b1; act_val[BIT_L] = ~flags_q[BIT_L]; end
      ACT_CLL: begin act_mask[BIT_L] = 1'b1; act_val[BIT_L] = 1'b0;            end
      ACT_STI: begin act_mask[BIT_I] = 1'b1; act_val[BIT_I] = 1'b1;            end
      ACT_CLI: begin act_mask[BIT_I] = 1'b1; act_val[BIT_I] = 1'b0;            end
      default: ;
    endcase
  end

  assign alu_res = (flags_q & ~bus.alu_we) | (bus.alu_f & bus.alu_we);

`ifdef FLAG_SHADOW_EN
  logic [NFLAGS-1:0] shadow_q;

  always_ff @(posedge clk4) begin
    if (!nreset)
      shadow_q <= '0;
    else if (!bus.nint_enter)
      shadow_q <= flags_q;
  end
`else
  logic unused_shadow_strobes;
  assign unused_shadow_strobes = bus.nint_enter ^ bus.nrti;
`endif

  // Lowest priority first; later assignments override earlier ones.
  always_comb begin
    flags_d = (alu_res & ~act_mask) | (act_val & act_mask);
    if (flag_wr)
      flags_d = bus.ibus[FLAG_LSB +: NFLAGS];
`ifdef FLAG_SHADOW_EN
    if (!bus.nint_enter) begin
      flags_d        = flags_q;
      flags_d[BIT_I] = 1'b0;
    end else if (!bus.nrti) begin
      flags_d = shadow_q;
    end
`endif
    flags_d = flags_d & ~RSVD_MASK;
  end

  always_ff @(posedge clk4) begin
    if (!nreset) begin
      flags_q <= '0;
      snap_q  <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      flags_q <= flags_d;
      sync1_q <= bus.nfpflags;
      sync2_q <= sync1_q;
      if (sync2_q)
        snap_q <= flags_q;
    end
  end

endmodule

// File: tb/tb_flag_reg_file.sv
// Self-checking bench for flag_reg_file: directed scenarios plus randomized run against a rule model.
module tb_flag_reg_file;

`ifdef FLAG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset;
  int   n_checks = 0;
  int   n_fail   = 0;

  flag_reg_file_if #(.BUS_W(8), .NFLAGS(6)) ifc ();

  flag_reg_file #(
    .BUS_W(8), .NFLAGS(6), .FLAG_LSB(2), .RSVD_MASK(6'b010000),
    .WA_FLAGS0(5'b01101), .WA_FLAGS1(5'b01110), .RA_FLAGS(5'b01101)
  ) dut (
    .clk4  (clk),
    .nreset(nreset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Behavioural model state
  logic [5:0] m_flags  = '0;
  logic [5:0] m_snap   = '0;
  logic [5:0] m_shadow = '0;
  bit         sync_pipe[$] = '{1'b1, 1'b1};

  task automatic model_edge();
    logic [5:0] nxt;
    logic [7:0] busv;
    bit         wr;
    bit         synced;
    busv = (ifc.raddr == 5'd13) ? {m_flags, 2'b00} : ifc.ibus_ext;
    wr   = (ifc.waddr == 5'd13) || (ifc.waddr == 5'd14);
    if (!nreset) begin
      m_flags = '0; m_snap = '0; m_shadow = '0;
      sync_pipe = '{1'b1, 1'b1};
      return;
    end
    for (int i = 0; i < 6; i++) begin
      if (SHADOW && !ifc.nint_enter)           nxt[i] = (i == 5) ? 1'b0 : m_flags[i];
      else if (SHADOW && !ifc.nrti)            nxt[i] = m_shadow[i];
      else if (wr)                             nxt[i] = busv[2+i];
      else if (ifc.action == 4'd1 && i == 2)   nxt[i] = ~m_flags[2];
      else if (ifc.action == 4'd2 && i == 2)   nxt[i] = 1'b0;
      else if (ifc.action == 4'd3 && i == 5)   nxt[i] = 1'b1;
      else if (ifc.action == 4'd4 && i == 5)   nxt[i] = 1'b0;
      else if (ifc.alu_we[i])                  nxt[i] = ifc.alu_f[i];
      else                                     nxt[i] = m_flags[i];
      if (i == 4) nxt[i] = 1'b0;
    end
    if (SHADOW && !ifc.nint_enter) m_shadow = m_flags;
    synced = sync_pipe.pop_front();
    if (synced) m_snap = m_flags;
    sync_pipe.push_back(ifc.nfpflags);
    m_flags = nxt;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.waddr = '0; ifc.raddr = '0; ifc.action = '0;
    ifc.alu_f = '0; ifc.alu_we = '0; ifc.ibus_ext = '0;
    ifc.nint_enter = 1'b1; ifc.nrti = 1'b1;
  endtask

  task automatic load_flags(input logic [5:0] f);
    ifc.waddr = 5'd13; ifc.ibus_ext = {f, 2'b00};
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    ifc.nfpflags = 1'b0;
    ifc.raddr = 5'd13;
    nreset = 1'b0;
    step(); step();
    n_checks++; if (ifc.flags !== 6'h00) begin n_fail++; $display("FAIL reset_flags: got %h want 00", ifc.flags); end
    n_checks++; if (ifc.ibus_oe !== 1'b0) begin n_fail++; $display("FAIL reset_ibus_z: oe got %b want 0", ifc.ibus_oe); end
    n_checks++; if (ifc.fpd_oe !== 1'b0) begin n_fail++; $display("FAIL reset_fpd_z: oe got %b want 0", ifc.fpd_oe); end
    ifc.nfpflags = 1'b1;
    idle();
    nreset = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_decode();
    for (int unsigned a = 0; a < 32; a++) begin
      ifc.waddr = 5'(a); ifc.raddr = 5'(a);
      #1;
      n_checks++; if (ifc.nflagwe !== !(a == 13 || a == 14)) begin n_fail++; $display("FAIL decode_nflagwe[%0d]: got %b", a, ifc.nflagwe); end
      n_checks++; if (ifc.nwrite_ir !== !(a == 15)) begin n_fail++; $display("FAIL decode_nwrite_ir[%0d]: got %b", a, ifc.nwrite_ir); end
      n_checks++; if (ifc.nread_agl !== !(a == 15)) begin n_fail++; $display("FAIL decode_nread_agl[%0d]: got %b", a, ifc.nread_agl); end
      step();
    end
    idle();
  endtask

  task automatic test_bus_write();
    logic [7:0] b;
    ifc.waddr = 5'd13; ifc.ibus_ext = 8'hFC;
    step();
    idle();
    n_checks++; if (ifc.flags !== 6'b101111) begin n_fail++; $display("FAIL bus_write_FC: got %b want 101111", ifc.flags); end
    ifc.raddr = 5'd13;
    #1;
    n_checks++; if (ifc.ibus_oe !== 1'b1 || ifc.ibus_drv !== 8'hBC) begin n_fail++; $display("FAIL bus_read_BC: oe %b val %h want 1 BC", ifc.ibus_oe, ifc.ibus_drv); end
    idle();
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      ifc.waddr = (k % 2 == 0) ? 5'd13 : 5'd14; ifc.ibus_ext = b;
      step();
      idle();
      n_checks++; if (ifc.flags !== ((b >> 2) & 8'h2F)) begin n_fail++; $display("FAIL bus_write_rand: wrote %h got %h want %h", b, ifc.flags, (b >> 2) & 8'h2F); end
    end
  endtask

  task automatic test_priority();
    ifc.waddr = 5'd13; ifc.ibus_ext = 8'h00; ifc.action = 4'd1;
    ifc.alu_we = 6'h3F; ifc.alu_f = 6'h3F;
    step();
    idle();
    n_checks++; if (ifc.flags !== 6'h00) begin n_fail++; $display("FAIL prio_buswrite: got %h want 00", ifc.flags); end
    ifc.action = 4'd1; ifc.alu_we = 6'b000100; ifc.alu_f = 6'b000000;
    step();
    idle();
    n_checks++; if (ifc.flags !== 6'h04) begin n_fail++; $display("FAIL prio_action_over_alu: got %h want 04", ifc.flags); end
    ifc.action = 4'd3; ifc.alu_we = 6'b000011; ifc.alu_f = 6'b000011;
    step();
    idle();
    n_checks++; if (ifc.flags !== 6'h27) begin n_fail++; $display("FAIL action_plus_alu: got %h want 27", ifc.flags); end
    ifc.action = 4'd7; ifc.alu_we = 6'h3F; ifc.alu_f = 6'h3F;
    step();
    idle();
    n_checks++; if (ifc.flags !== 6'h2F) begin n_fail++; $display("FAIL nop_action_alu: got %h want 2F", ifc.flags); end
  endtask

  task automatic test_front_panel();
    load_flags(6'h21);
    ifc.nfpflags = 1'b0;
    repeat (3) step();
    n_checks++; if (ifc.fpd_oe !== 1'b1 || ifc.fpd !== 8'h84) begin n_fail++; $display("FAIL fp_snapshot: oe %b val %h want 1 84", ifc.fpd_oe, ifc.fpd); end
    ifc.alu_we = 6'b000010; ifc.alu_f = 6'b000010;
    step();
    idle();
    repeat (2) step();
    n_checks++; if (ifc.flags !== 6'h23) begin n_fail++; $display("FAIL fp_alu_z: got %h want 23", ifc.flags); end
    n_checks++; if (ifc.fpd !== 8'h84) begin n_fail++; $display("FAIL fp_frozen: got %h want 84", ifc.fpd); end
    ifc.nfpflags = 1'b1;
    #1;
    n_checks++; if (ifc.fpd_oe !== 1'b0) begin n_fail++; $display("FAIL fp_release_z: oe %b want 0", ifc.fpd_oe); end
    repeat (3) step();
    ifc.nfpflags = 1'b0;
    #1;
    n_checks++; if (ifc.fpd_oe !== 1'b1 || ifc.fpd !== 8'h8C) begin n_fail++; $display("FAIL fp_second_req: oe %b val %h want 1 8C", ifc.fpd_oe, ifc.fpd); end
    step();
    ifc.nfpflags = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_shadow();
    load_flags(6'h2C);
    ifc.nint_enter = 1'b0;
    step();
    ifc.nint_enter = 1'b1;
    n_checks++; if (ifc.flags !== (SHADOW ? 6'h0C : 6'h2C)) begin n_fail++; $display("FAIL shadow_enter: got %h want %h", ifc.flags, SHADOW ? 6'h0C : 6'h2C); end
    ifc.nrti = 1'b0;
    step();
    ifc.nrti = 1'b1;
    n_checks++; if (ifc.flags !== 6'h2C) begin n_fail++; $display("FAIL shadow_rti: got %h want 2C", ifc.flags); end
    // Simultaneous strobes plus a bus write: entry takes precedence
    ifc.nint_enter = 1'b0; ifc.nrti = 1'b0; ifc.waddr = 5'd13; ifc.ibus_ext = 8'hFC;
    step();
    idle();
    n_checks++; if (ifc.flags !== (SHADOW ? 6'h0C : 6'h2F)) begin n_fail++; $display("FAIL shadow_both: got %h want %h", ifc.flags, SHADOW ? 6'h0C : 6'h2F); end
    ifc.nint_enter = 1'b0;
    step();
    ifc.nint_enter = 1'b1;
    ifc.nrti = 1'b0;
    step();
    ifc.nrti = 1'b1;
    n_checks++; if (ifc.flags !== (SHADOW ? 6'h0C : 6'h2F)) begin n_fail++; $display("FAIL shadow_overwrite: got %h want %h", ifc.flags, SHADOW ? 6'h0C : 6'h2F); end
  endtask

  task automatic test_reset_mid_request();
    load_flags(6'h2F);
    ifc.nfpflags = 1'b0;
    repeat (3) step();
    nreset = 1'b0;
    repeat (2) step();
    n_checks++; if (ifc.flags !== 6'h00 || ifc.fpd_oe !== 1'b0) begin n_fail++; $display("FAIL midreq_in_reset: flags %h oe %b want 00 0", ifc.flags, ifc.fpd_oe); end
    nreset = 1'b1;
    repeat (3) step();
    n_checks++; if (ifc.flags !== 6'h00 || ifc.fpd_oe !== 1'b1 || ifc.fpd !== 8'h00) begin n_fail++; $display("FAIL midreq_after_reset: flags %h oe %b fpd %h want 00 1 00", ifc.flags, ifc.fpd_oe, ifc.fpd); end
    ifc.nfpflags = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_random();
    bit exp_oe;
    for (int c = 0; c < 400; c++) begin
      ifc.waddr     = ($urandom_range(0, 3) == 0) ? 5'(13 + $urandom_range(0, 1)) : 5'($urandom);
      ifc.raddr     = ($urandom_range(0, 2) == 0) ? 5'd13 : 5'($urandom);
      ifc.action    = 4'($urandom_range(0, 7));
      ifc.alu_f     = 6'($urandom);
      ifc.alu_we    = 6'($urandom);
      ifc.ibus_ext  = 8'($urandom);
      ifc.nint_enter = ($urandom_range(0, 7) != 0);
      ifc.nrti       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) ifc.nfpflags = ~ifc.nfpflags;
      nreset = ($urandom_range(0, 49) != 0);
      #1;
      exp_oe = nreset && (ifc.raddr == 5'd13);
      n_checks++;
      if (ifc.ibus_oe !== exp_oe || (exp_oe && ifc.ibus_drv !== {m_flags, 2'b00})) begin
        n_fail++; $display("FAIL rand_ibus[%0d]: oe %b val %h want %b %h", c, ifc.ibus_oe, ifc.ibus_drv, exp_oe, {m_flags, 2'b00});
      end
      exp_oe = nreset && !ifc.nfpflags;
      n_checks++;
      if (ifc.fpd_oe !== exp_oe || (exp_oe && ifc.fpd !== {m_snap, 2'b00})) begin
        n_fail++; $display("FAIL rand_fpd[%0d]: oe %b val %h want %b %h", c, ifc.fpd_oe, ifc.fpd, exp_oe, {m_snap, 2'b00});
      end
      step();
      n_checks++;
      if (ifc.flags !== m_flags) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got %h want %h", c, ifc.flags, m_flags);
      end
    end
    nreset = 1'b1;
    ifc.nfpflags = 1'b1;
    idle();
    repeat (3) step();
  endtask

  initial begin
    nreset = 1'b1;
    ifc.nfpflags = 1'b1;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_decode();
    test_bus_write();
    test_priority();
    test_front_panel();
    test_shadow();
    test_reset_mid_request();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
